// File: rtl/cdb_arbiter.sv
// Round-robin arbiter for the common data bus: picks one finished execution-unit result
// per cycle and drives a registered broadcast to every reservation station.
module cdb_arbiter #(
    parameter int NUM_UNITS   = 4,
    parameter int RS_ID_WIDTH = 5,
    parameter int DATA_WIDTH  = 32,
    localparam int UW = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NUM_UNITS-1:0]                    unit_valid,
    output logic [NUM_UNITS-1:0]                    unit_ready,
    input  logic [NUM_UNITS-1:0][RS_ID_WIDTH-1:0]   unit_rs_id,
    input  logic [NUM_UNITS-1:0][DATA_WIDTH-1:0]    unit_value,
    output logic                                    cdb_valid,
    output logic [RS_ID_WIDTH-1:0]                  cdb_rs_id,
    output logic [DATA_WIDTH-1:0]                   cdb_value,
    output logic [UW-1:0]                           cdb_unit
);

    localparam int IW = UW + 1;

    logic [UW-1:0] ptr_r;
    logic [UW-1:0] ptr_nxt_s;
    logic [UW-1:0] winner_s;
    logic [IW-1:0] idx_s;
    logic          grant_s;

    // Round-robin search starting at ptr_r; the first valid unit wins and gets the one-hot ready.
    always_comb begin
        grant_s    = 1'b0;
        winner_s   = {UW{1'b0}};
        idx_s      = {IW{1'b0}};
        unit_ready = {NUM_UNITS{1'b0}};
        for (int k = 0; k < NUM_UNITS; k++) begin
            idx_s = {1'b0, ptr_r} + IW'(k);
            if (idx_s >= IW'(NUM_UNITS)) begin
                idx_s = idx_s - IW'(NUM_UNITS);
            end else begin
                idx_s = idx_s;
            end
            if (!grant_s && unit_valid[idx_s[UW-1:0]]) begin
                grant_s  = 1'b1;
                winner_s = idx_s[UW-1:0];
            end else begin
                grant_s  = grant_s;
                winner_s = winner_s;
            end
        end
        // Nothing is taken while reset is held, even though units may still be offering.
        if (rst) begin
            grant_s = 1'b0;
        end else if (grant_s) begin
            unit_ready[winner_s] = 1'b1;
        end else begin
            unit_ready = {NUM_UNITS{1'b0}};
        end
        if (winner_s == UW'(NUM_UNITS - 1)) begin
            ptr_nxt_s = {UW{1'b0}};
        end else begin
            ptr_nxt_s = winner_s + UW'(1);
        end
    end

    // Pointer advance and registered broadcast; payload holds when no result is taken.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r     <= {UW{1'b0}};
            cdb_valid <= 1'b0;
            cdb_rs_id <= {RS_ID_WIDTH{1'b0}};
            cdb_value <= {DATA_WIDTH{1'b0}};
            cdb_unit  <= {UW{1'b0}};
        end else begin
            cdb_valid <= grant_s;
            if (grant_s) begin
                ptr_r     <= ptr_nxt_s;
                cdb_rs_id <= unit_rs_id[winner_s];
                cdb_value <= unit_value[winner_s];
                cdb_unit  <= winner_s;
            end else begin
                ptr_r     <= ptr_r;
                cdb_rs_id <= cdb_rs_id;
                cdb_value <= cdb_value;
                cdb_unit  <= cdb_unit;
            end
        end
    end

endmodule
